// File: rtl/jogo_memoria_pkg.sv
// Shared definitions for the memory-game core: FSM state codes,
// configuracao bit positions and the LFSR feedback polynomial.
package jogo_memoria_pkg;

  typedef enum logic [3:0] {
    S_INICIAL      = 4'h0,
    S_PREPARA      = 4'h1,
    S_MOSTRA_LED   = 4'h2,
    S_MOSTRA_PAUSA = 4'h3,
    S_ESPERA       = 4'h4,
    S_REGISTRA     = 4'h5,
    S_COMPARA      = 4'h6,
    S_PROX_JOGADA  = 4'h7,
    S_ESPERA_NOVA  = 4'h8,
    S_ESCREVE_NOVA = 4'h9,
    S_PROX_RODADA  = 4'hA,
    S_GANHOU       = 4'hB,
    S_PERDEU       = 4'hC,
    S_TIMEOUT      = 4'hD
  } estado_t;

  localparam int unsigned CFG_DEMO = 0;
  localparam int unsigned CFG_TMO  = 1;
  localparam int unsigned CFG_SRC  = 2;

  // Taps 16,14,13,11 of x^16+x^14+x^13+x^11+1 mapped to bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] v);
    return ^(v & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/temporizador_param.sv
// Loadable down-counter; o_fim flags a count of zero and the counter
// holds there until reloaded.
module temporizador_param #(
  parameter int unsigned W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_carrega,
  input  logic         i_habilita,
  input  logic [W-1:0] i_valor,
  output logic         o_fim
);

  logic [W-1:0] r_cont;

  // Load has priority over counting; stop at zero.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cont <= '0;
    end else if (i_carrega) begin
      r_cont <= i_valor;
    end else if (i_habilita && (r_cont != '0)) begin
      r_cont <= r_cont - W'(1);
    end
  end

  assign o_fim = (r_cont == '0);

endmodule

// File: rtl/jogo_memoria_param.sv
// Memory-game core: stores the colour sequence, replays it on one-hot
// LEDs, checks the player's replay and extends the sequence each round.
module jogo_memoria_param
  import jogo_memoria_pkg::*;
#(
  parameter int unsigned N_BOTOES     = 4,
  parameter int unsigned MAX_RODADAS  = 16,
  parameter int unsigned DEMO_RODADAS = 4,
  parameter int unsigned T_LED        = 1000,
  parameter int unsigned T_PAUSA      = 500,
  parameter int unsigned T_TIMEOUT    = 5000,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          jogar,
  input  logic [2:0]                    configuracao,
  input  logic [N_BOTOES-1:0]           botoes,
  output logic [N_BOTOES-1:0]           leds,
  output logic                          ganhou,
  output logic                          perdeu,
  output logic                          timeout,
  output logic                          pronto,
  output logic [$clog2(MAX_RODADAS):0]  rodada,
  output logic [3:0]                    db_estado
);

  localparam int unsigned IW  = $clog2(N_BOTOES);
  localparam int unsigned AW  = $clog2(MAX_RODADAS);
  localparam int unsigned RW  = AW + 1;
  localparam int unsigned TLW = $clog2((T_LED > T_PAUSA) ? T_LED : T_PAUSA) + 1;
  localparam int unsigned TTW = $clog2(T_TIMEOUT) + 1;
  localparam logic [TTW-1:0] TMO_VALOR = TTW'(T_TIMEOUT - 1);
  localparam logic [AW-1:0]  UM_A = AW'(1);
  localparam logic [RW-1:0]  UM_R = RW'(1);

  estado_t               r_estado, w_prox;
  logic [15:0]           r_lfsr;
  logic [N_BOTOES-1:0]   r_botoes_q;
  logic [2:0]            r_cfg;
  logic [AW-1:0]         r_endereco;
  logic [RW-1:0]         r_rodada;
  logic [IW-1:0]         r_jogada;
  logic [IW-1:0]         r_mem [MAX_RODADAS];

  logic [IW-1:0]         w_indice, w_elem;
  logic                  w_evento, w_ultimo, w_acertou;
  logic [RW-1:0]         w_limite;
  logic                  w_led_carrega, w_led_hab, w_led_fim;
  logic [TLW-1:0]        w_led_valor;
  logic                  w_tmo_carrega, w_tmo_hab, w_tmo_fim;

  assign w_elem    = r_lfsr[IW-1:0];
  assign w_evento  = (|botoes) & ~(|r_botoes_q);
  assign w_ultimo  = ({1'b0, r_endereco} == (r_rodada - UM_R));
  assign w_acertou = (r_mem[r_endereco] == r_jogada);
  assign w_limite  = r_cfg[CFG_DEMO] ? RW'(DEMO_RODADAS) : RW'(MAX_RODADAS);

  // Priority encoder: lowest set button wins.
  always_comb begin
    w_indice = '0;
    for (int unsigned i = N_BOTOES; i > 0; i--) begin
      if (botoes[i-1]) w_indice = IW'(i - 1);
    end
  end

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_estado <= S_INICIAL;
    else        r_estado <= w_prox;
  end

  // Next-state and LED/timer-enable decode.
  always_comb begin
    w_prox    = r_estado;
    leds      = '0;
    w_led_hab = 1'b0;
    w_tmo_hab = 1'b0;
    case (r_estado)
      S_INICIAL:      if (jogar) w_prox = S_PREPARA;
      S_PREPARA:      w_prox = S_MOSTRA_LED;
      S_MOSTRA_LED: begin
        leds[r_mem[r_endereco]] = 1'b1;
        w_led_hab = 1'b1;
        if (w_led_fim) w_prox = S_MOSTRA_PAUSA;
      end
      S_MOSTRA_PAUSA: begin
        w_led_hab = 1'b1;
        if (w_led_fim) w_prox = w_ultimo ? S_ESPERA : S_MOSTRA_LED;
      end
      S_ESPERA, S_ESPERA_NOVA: begin
        leds      = botoes;
        w_tmo_hab = 1'b1;
        if (w_evento)
          w_prox = (r_estado == S_ESPERA) ? S_REGISTRA : S_ESCREVE_NOVA;
        else if (r_cfg[CFG_TMO] && w_tmo_fim)
          w_prox = S_TIMEOUT;
      end
      S_REGISTRA:     w_prox = S_COMPARA;
      S_COMPARA: begin
        if (!w_acertou)                 w_prox = S_PERDEU;
        else if (!w_ultimo)             w_prox = S_PROX_JOGADA;
        else if (r_rodada == w_limite)  w_prox = S_GANHOU;
        else w_prox = r_cfg[CFG_SRC] ? S_ESCREVE_NOVA : S_ESPERA_NOVA;
      end
      S_PROX_JOGADA:  w_prox = S_ESPERA;
      S_ESCREVE_NOVA: w_prox = S_PROX_RODADA;
      S_PROX_RODADA:  w_prox = S_MOSTRA_LED;
      S_GANHOU, S_PERDEU, S_TIMEOUT: if (jogar) w_prox = S_PREPARA;
      default:        w_prox = S_INICIAL;
    endcase
  end

  // Timers are reloaded on the transition into the state they time, so the
  // state lasts exactly the programmed number of cycles.
  assign w_led_carrega = (w_prox != r_estado) &&
                         ((w_prox == S_MOSTRA_LED) || (w_prox == S_MOSTRA_PAUSA));
  assign w_led_valor   = (w_prox == S_MOSTRA_LED) ? TLW'(T_LED - 1) : TLW'(T_PAUSA - 1);
  assign w_tmo_carrega = (w_prox != r_estado) &&
                         ((w_prox == S_ESPERA) || (w_prox == S_ESPERA_NOVA));

  temporizador_param #(.W(TLW)) u_tmr_led (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_carrega  (w_led_carrega),
    .i_habilita (w_led_hab),
    .i_valor    (w_led_valor),
    .o_fim      (w_led_fim)
  );

  temporizador_param #(.W(TTW)) u_tmr_tmo (
    .i_clk      (clock),
    .i_rst_n    (reset),
    .i_carrega  (w_tmo_carrega),
    .i_habilita (w_tmo_hab),
    .i_valor    (TMO_VALOR),
    .o_fim      (w_tmo_fim)
  );

  // LFSR, button history, config latch, address/round counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_lfsr     <= LFSR_SEED;
      r_botoes_q <= '0;
      r_cfg      <= '0;
      r_endereco <= '0;
      r_rodada   <= '0;
      r_jogada   <= '0;
    end else begin
      r_lfsr     <= {r_lfsr[14:0], lfsr_fb(r_lfsr)};
      r_botoes_q <= botoes;
      case (r_estado)
        S_PREPARA: begin
          r_cfg      <= configuracao;
          r_rodada   <= UM_R;
          r_endereco <= '0;
        end
        S_MOSTRA_PAUSA: if (w_led_fim) r_endereco <= w_ultimo ? '0 : r_endereco + UM_A;
        S_ESPERA, S_ESPERA_NOVA: if (w_evento) r_jogada <= w_indice;
        S_PROX_JOGADA:  r_endereco <= r_endereco + UM_A;
        S_PROX_RODADA: begin
          r_rodada   <= r_rodada + UM_R;
          r_endereco <= '0;
        end
        default: ;
      endcase
    end
  end

  // Sequence storage; contents are not reset.
  always_ff @(posedge clock) begin
    if (r_estado == S_PREPARA)
      r_mem[0] <= w_elem;
    else if (r_estado == S_ESCREVE_NOVA)
      r_mem[r_rodada[AW-1:0]] <= r_cfg[CFG_SRC] ? w_elem : r_jogada;
  end

  assign ganhou    = (r_estado == S_GANHOU);
  assign perdeu    = (r_estado == S_PERDEU);
  assign timeout   = (r_estado == S_TIMEOUT);
  assign pronto    = ganhou | perdeu | timeout;
  assign rodada    = r_rodada;
  assign db_estado = r_estado;

endmodule

// File: tb/tb_jogo_memoria_param.sv
// Directed bench for jogo_memoria_param with small timing parameters.
module tb_jogo_memoria_param;

  localparam int TL = 4;
  localparam int TP = 2;

  logic       clock = 1'b0;
  logic       reset;
  logic       jogar;
  logic [2:0] configuracao;
  logic [3:0] botoes;
  logic [3:0] leds;
  logic       ganhou, perdeu, timeout, pronto;
  logic [4:0] rodada;
  logic [3:0] db_estado;

  int n_assert = 0;
  int n_fail   = 0;

  logic [15:0] m_lfsr;
  logic [1:0]  seq [$];
  logic [3:0]  q_exp [$];

  jogo_memoria_param #(
    .N_BOTOES(4), .MAX_RODADAS(16), .DEMO_RODADAS(4),
    .T_LED(TL), .T_PAUSA(TP), .T_TIMEOUT(10), .LFSR_SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .jogar(jogar), .configuracao(configuracao),
    .botoes(botoes), .leds(leds), .ganhou(ganhou), .perdeu(perdeu),
    .timeout(timeout), .pronto(pronto), .rodada(rodada), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Reference Fibonacci LFSR, x^16+x^14+x^13+x^11+1, shifting left.
  always @(posedge clock or negedge reset) begin
    if (!reset) m_lfsr <= 16'hACE1;
    else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end, expected finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [3:0] oh(input logic [1:0] v);
    logic [3:0] t;
    t = '0;
    t[v] = 1'b1;
    return t;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic wait_state(input logic [3:0] s, input int budget, input string tag);
    int n;
    n = 0;
    while (db_estado !== s && n < budget) begin
      @(negedge clock);
      n++;
    end
    chk(tag, db_estado, s);
  endtask

  task automatic press(input logic [1:0] v);
    botoes = oh(v);
    @(negedge clock);
    botoes = '0;
  endtask

  task automatic iniciar(input logic [2:0] cfg);
    configuracao = cfg;
    jogar = 1'b1;
    @(negedge clock);
    jogar = 1'b0;
    chk("prepara", db_estado, 4'h1);
    chk("prepara_flags", {ganhou, perdeu, timeout, pronto}, 4'b0000);
    seq.delete();
    seq.push_back(m_lfsr[1:0]);
  endtask

  // Queue the expected replay, then compare each LED phase as it appears.
  task automatic mostrar(input int r);
    int n;
    logic [3:0] e;
    foreach (seq[i]) q_exp.push_back(oh(seq[i]));
    while (q_exp.size() > 0) begin
      wait_state(4'h2, 100, "chega_mostra");
      e = q_exp.pop_front();
      chk("leds_mostra", leds, e);
      chk("rodada", rodada, r);
      n = 0;
      while (db_estado === 4'h2 && n < 100) begin @(negedge clock); n++; end
      chk("dur_led", n, TL);
      chk("leds_pausa", leds, '0);
      n = 0;
      while (db_estado === 4'h3 && n < 100) begin @(negedge clock); n++; end
      chk("dur_pausa", n, TP);
    end
    wait_state(4'h4, 100, "chega_espera");
  endtask

  // Correct replay of the first n elements; returns at press+3.
  task automatic responder(input int n);
    for (int i = 0; i < n; i++) begin
      wait_state(4'h4, 50, "espera_jogada");
      press(seq[i]);
      chk("registra", db_estado, 4'h5);
      @(negedge clock);
      chk("compara", db_estado, 4'h6);
      @(negedge clock);
      if (i < n - 1) chk("prox_jogada", db_estado, 4'h7);
    end
  endtask

  initial begin
    logic [1:0] c;
    logic [3:0] m;
    reset = 1'b0; jogar = 1'b0; configuracao = '0; botoes = '0;
    ciclos(3);
    chk("rst_estado", db_estado, 4'h0);
    chk("rst_saidas", {leds, ganhou, perdeu, timeout, pronto}, '0);
    chk("rst_rodada", rodada, '0);
    reset = 1'b1;
    ciclos($urandom_range(3, 9));
    chk("inicial_parado", db_estado, 4'h0);

    // Full mode, player-chosen extension, play to the round limit.
    iniciar(3'b000);
    for (int r = 1; r <= 16; r++) begin
      mostrar(r);
      responder(r);
      if (r < 16) begin
        chk("espera_nova", db_estado, 4'h8);
        c = 2'((r * 3 + 1) % 4);
        press(c);
        seq.push_back(c);
        chk("escreve_nova", db_estado, 4'h9);
      end
    end
    chk("ganhou_estado", db_estado, 4'hB);
    chk("ganhou_flags", {ganhou, perdeu, timeout, pronto}, 4'b1001);
    chk("ganhou_rodada", rodada, 16);
    chk("ganhou_leds", leds, '0);
    ciclos(5);
    chk("ganhou_retido", {ganhou, pronto}, 2'b11);

    // Demo mode; configuracao changes mid-game must not matter.
    iniciar(3'b001);
    for (int r = 1; r <= 4; r++) begin
      mostrar(r);
      responder(r);
      if (r == 1) configuracao = 3'b110;
      if (r < 4) begin
        chk("demo_espera_nova", db_estado, 4'h8);
        ciclos(15);
        chk("demo_sem_tmo", db_estado, 4'h8);
        chk("demo_tmo_flag", timeout, 1'b0);
        c = 2'((r + 2) % 4);
        press(c);
        seq.push_back(c);
      end
    end
    chk("demo_ganhou", db_estado, 4'hB);
    chk("demo_ganhou_flag", ganhou, 1'b1);
    chk("demo_rodada", rodada, 4);

    // Wrong press at round 3, second position.
    iniciar(3'b000);
    for (int r = 1; r <= 2; r++) begin
      mostrar(r);
      responder(r);
      c = 2'(r);
      press(c);
      seq.push_back(c);
    end
    mostrar(3);
    press(seq[0]);
    wait_state(4'h4, 20, "erro_espera");
    c = seq[1] + 2'd1;
    botoes = oh(c);
    @(negedge clock); botoes = '0;
    chk("erro_k1", db_estado, 4'h5);
    @(negedge clock);
    chk("erro_k2", db_estado, 4'h6);
    chk("erro_k2_flag", perdeu, 1'b0);
    @(negedge clock);
    chk("erro_k3", db_estado, 4'hC);
    chk("perdeu_flags", {ganhou, perdeu, timeout, pronto}, 4'b0101);
    chk("perdeu_leds", leds, '0);

    // Restart with timeout enabled; idle in ESPERA.
    iniciar(3'b010);
    mostrar(1);
    ciclos(9);
    chk("tmo_t9", db_estado, 4'h4);
    @(negedge clock);
    chk("tmo_t10", db_estado, 4'hD);
    chk("tmo_flags", {ganhou, perdeu, timeout, pronto}, 4'b0011);
    chk("tmo_leds", leds, '0);

    // Timeout disabled: stays waiting; jogar ignored mid-game.
    iniciar(3'b000);
    mostrar(1);
    jogar = 1'b1;
    ciclos(3);
    jogar = 1'b0;
    chk("jogar_ignorado", db_estado, 4'h4);
    ciclos(37);
    chk("sem_tmo_estado", db_estado, 4'h4);
    chk("sem_tmo_flag", timeout, 1'b0);
    press(seq[0]);
    wait_state(4'h8, 20, "sem_tmo_espera_nova");
    press(2'd3);
    seq.push_back(2'd3);

    // Asynchronous reset in the middle of the replay.
    wait_state(4'h2, 100, "rst_mostra");
    #2 reset = 1'b0;
    #1;
    chk("rst_async_estado", db_estado, 4'h0);
    chk("rst_async_saidas", {leds, ganhou, perdeu, timeout, pronto}, '0);
    chk("rst_async_rodada", rodada, '0);
    @(negedge clock);
    reset = 1'b1;
    ciclos(2);
    chk("pos_rst_inicial", db_estado, 4'h0);

    // LFSR extension; simultaneous and held-button presses.
    iniciar(3'b100);
    mostrar(1);
    responder(1);
    chk("src1_escreve", db_estado, 4'h9);
    seq.push_back(m_lfsr[1:0]);
    mostrar(2);
    m = 4'b1111 << seq[0];
    botoes = m;
    @(negedge clock); botoes = oh(seq[0]);
    chk("multi_registra", db_estado, 4'h5);
    @(negedge clock);
    chk("multi_compara", db_estado, 4'h6);
    @(negedge clock);
    chk("multi_menor_indice", db_estado, 4'h7);
    @(negedge clock);
    chk("multi_espera", db_estado, 4'h4);
    botoes = oh(seq[0]) | oh(seq[0] + 2'd1);
    ciclos(3);
    chk("segundo_sem_evento", db_estado, 4'h4);
    chk("leds_espera", leds, oh(seq[0]) | oh(seq[0] + 2'd1));
    botoes = '0;
    ciclos(2);
    chk("solto_espera", db_estado, 4'h4);
    press(seq[1]);
    chk("src1_registra", db_estado, 4'h5);
    @(negedge clock);
    chk("src1_compara", db_estado, 4'h6);
    @(negedge clock);
    chk("src1_rodada2_fim", db_estado, 4'h9);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
